soc_bus_initiator: RTL
======================

// Module: soc_bus_initiator
// PURPOSE
//  Bus initiator (master) side of the soc_if CSR bus: turns queued command
//  words (addr/wdat/we) into single bus transactions and returns a response
//  (rdat/err) per command. Sits between a debug/host source (UART bridge,
//  test sequencer) and the CSR block. Adds bus timeout and alignment checks.
// PARAMETERS
//  AW          32   address width (bus_addr, cmd_addr)
//  DW          32   data width (wdat/rdat); only full-word access
//  FIFO_DEPTH  4    command FIFO entries, power of 2, >=2
//  TIMEOUT_CYC 255  max cycles bus_vld may wait for bus_rdy; 0 = no timeout
// PORTS
//  clk        in   1   clock
//  rst        in   1   sync reset, active-high
//  cmd_vld    in   1   command valid
//  cmd_rdy    out  1   command FIFO not full
//  cmd_we     in   1   1=write, 0=read
//  cmd_addr   in   AW  byte address, must be word aligned
//  cmd_wdat   in   DW  write data
//  rsp_vld    out  1   response valid, held until rsp_rdy
//  rsp_rdy    in   1   response accepted
//  rsp_rdat   out  DW  read data (0 for writes/errors)
//  rsp_err    out  1   1=timeout or misaligned
//  bus_vld    out  1   bus request valid
//  bus_we     out  1   bus write enable
//  bus_addr   out  AW  bus address
//  bus_wdat   out  DW  bus write data
//  bus_rdat   in   DW  bus read data, valid when bus_vld&bus_rdy
//  bus_rdy    in   1   bus completion (may be tied HI)
//  err_cnt    out  8   saturating error counter
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, counters 0; cmd_rdy=1 after.
//  Reset mid-transaction: in-flight and queued commands dropped, no rsp.
//  Push when cmd_vld&cmd_rdy; cmd_rdy = !full only (no same-cycle
//   pop-through when full). Empty FIFO: FSM stays IDLE.
//  FSM IDLE: FIFO non-empty -> pop; aligned -> REQ, bus_* loaded at that edge;
//   cmd_addr[1:0]!=0 -> RSP directly, rsp_err=1, rsp_rdat=0, no bus access.
//  REQ: bus_vld=1, bus_* stable. On bus_vld&bus_rdy: capture bus_rdat
//   (reads) or 0 (writes), rsp_err=0, bus_vld->0, go RSP.
//   Timeout: TIMEOUT_CYC cycles in REQ without rdy -> bus_vld->0,
//   rsp_err=1, rsp_rdat=0, go RSP. Counter clears on entering REQ.
//  RSP: rsp_vld=1, rsp_* stable until rsp_vld&rsp_rdy -> IDLE.
//  Latency, rdy=HI, rsp_rdy=HI, idle: push edge E0, bus_vld high E1-E2,
//   rsp_vld high E2-E3. One transaction per 3 cycles sustained.
//  err_cnt +1 per error response at RSP entry, saturates at 255.
//  FIFO pointers wrap modulo FIFO_DEPTH; push+pop same edge keeps count.
//  bus_rdy while !bus_vld is ignored.
// TESTING
//  1 write 0x0000_0004 data 0xA5, rdy=HI -> bus_vld 1 cycle, we=1,
//    wdat=0xA5; rsp_vld 2 cycles after push, err=0, rdat=0.
//  2 read 0x8, rdy=HI, bus_rdat=0x8000_0042 -> rsp_rdat=0x8000_0042, err=0.
//  3 rdy low 3 cycles, TIMEOUT_CYC=255 -> bus_vld held 4 cycles, addr/wdat
//    stable, normal rsp; rdy never -> abort after 255 cycles, err=1,
//    err_cnt=1.
//  4 read 0x6 -> no bus_vld, rsp_err=1, rsp_rdat=0, err_cnt increments.
//  5 rsp_rdy=0, push 5 cmds -> 1 in RSP, 4 in FIFO, cmd_rdy=0; release
//    rsp_rdy -> 5 responses in order, cmd_rdy back to 1.
//  6 rst=1 while REQ with 2 queued -> next cycle bus_vld=0, cmd_rdy=1,
//    no rsp_vld thereafter.

Source files
------------

// File: rtl/soc_bus_initiator.sv
// CSR bus initiator: queued commands become single soc_if transactions, one response each.
// Latency push->bus_vld 1 cycle, ->rsp_vld 2 cycles; cmd_rdy drops when the FIFO is full, rsp held until rsp_rdy.

module soc_bus_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module soc_bus_initiator #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdat,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [DW-1:0] rsp_rdat,
  output logic          rsp_err,
  output logic          bus_vld,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdat,
  input  logic [DW-1:0] bus_rdat,
  input  logic          bus_rdy,
  output logic [7:0]    err_cnt
);
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCW-1:0] TLIM = TCW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t         state;
  state_t         state_nxt;
  cmd_t           cmd_in;
  cmd_t           head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           misaligned;
  logic           timeout;
  logic           err_set;
  logic [TCW-1:0] tcnt;

  assign cmd_in  = '{we: cmd_we, addr: cmd_addr, wdat: cmd_wdat};
  assign cmd_rdy = !fifo_full;
  assign push    = cmd_vld && !fifo_full;
  assign pop     = (state == IDLE) && !fifo_empty;

  soc_bus_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign misaligned = |head.addr[1:0];
  assign timeout    = (TIMEOUT_CYC != 0) && (tcnt == TLIM);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = misaligned ? RSP : REQ;
          err_set   = misaligned;
        end
      end
      REQ: begin
        if (bus_rdy) begin
          state_nxt = RSP;
        end else if (timeout) begin
          state_nxt = RSP;
          err_set   = 1'b1;
        end
      end
      RSP: begin
        if (rsp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus_vld = (state == REQ);
  assign rsp_vld = (state == RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we   <= 1'b0;
      bus_addr <= '0;
      bus_wdat <= '0;
      rsp_rdat <= '0;
      rsp_err  <= 1'b0;
      err_cnt  <= '0;
      tcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (misaligned) begin
              rsp_err  <= 1'b1;
              rsp_rdat <= '0;
            end else begin
              bus_we   <= head.we;
              bus_addr <= head.addr;
              bus_wdat <= head.wdat;
              tcnt     <= '0;
            end
          end
        end
        REQ: begin
          if (bus_rdy) begin
            rsp_rdat <= bus_we ? '0 : bus_rdat;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_rdat <= '0;
            rsp_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule
